// File: rtl/ddram_client_pkg.sv
// Shared types and helpers for the DDR3 core-side client.
// State encoding plus the word-select and byte-swap helpers used on the data paths.
package ddram_client_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT,
    DONE
  } state_t;

  localparam int LINE_W = 64;
  localparam int WORD_W = 16;

  // Pick one 16-bit word out of a 64-bit line; sel=0 is the lowest word.
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        sel);
    logic [WORD_W-1:0] w;
    case (sel)
      2'd0:    w = line[15:0];
      2'd1:    w = line[31:16];
      2'd2:    w = line[47:32];
      default: w = line[63:48];
    endcase
    return w;
  endfunction

  // Exchange the two bytes of a 16-bit word (68k byte order conversion).
  function automatic logic [WORD_W-1:0] bswap16(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/ddram_line_cache.sv
// One-line read cache: tag, valid bit and a 64-bit line.
// Filled on every completed downstream read; a core write that lands in the held
// line patches the stored word so later hits never return stale data.
module ddram_line_cache
  import ddram_client_pkg::*;
#(
  parameter int ADDR_W = 28
) (
  input  logic              DDRAM_CLK,
  input  logic              reset,
  input  logic [ADDR_W-4:0] lookup_tag,
  output logic              hit,
  output logic [LINE_W-1:0] line,
  input  logic              fill_en,
  input  logic [ADDR_W-4:0] fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              wr_en,
  input  logic [ADDR_W-4:0] wr_tag,
  input  logic [1:0]        wr_sel,
  input  logic [WORD_W-1:0] wr_data
);

  logic              valid;
  logic [ADDR_W-4:0] tag;

  // Full-width tag compare, so lines far apart in the address space never alias.
  assign hit = valid && (tag == lookup_tag);

  // Fill from downstream, or merge a core write into the held line (write-through).
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      line  <= '0;
    end else if (fill_en) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      line  <= fill_line;
    end else if (wr_en && valid && (tag == wr_tag)) begin
      case (wr_sel)
        2'd0:    line[15:0]  <= wr_data;
        2'd1:    line[31:16] <= wr_data;
        2'd2:    line[47:32] <= wr_data;
        default: line[63:48] <= wr_data;
      endcase
    end
  end

endmodule

// File: rtl/ddram_client.sv
// Core-side front end for the 16-bit DDR3 port.
// Turns single-word core requests into the toggle req/ack handshake of the DDR3 stage
// and returns the addressed word of the 64-bit line read back.
// Build option: define DDRAM_CLIENT_CACHE_EN to keep the last fetched line so reads
// that fall in it complete without a downstream access.
module ddram_client
  import ddram_client_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int WORD_SWAP = 0
) (
  input  logic              DDRAM_CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic [ADDR_W-1:0] wraddr,
  output logic [WORD_W-1:0] wr_din,
  output logic              we_req,
  input  logic              we_ack,
  output logic [ADDR_W-1:0] rdaddr,
  input  logic [LINE_W-1:0] rd_dout,
  output logic              rd_req,
  input  logic              rd_ack
);

  state_t            state;
  logic [1:0]        sel_q;
  logic [WORD_W-1:0] word_q;
  logic              is_rd;
  logic              accept;
  logic              cache_hit;
  logic [WORD_W-1:0] hit_word;

  // The same swap serves both directions, so the core always sees its own byte order.
  function automatic logic [WORD_W-1:0] order(input logic [WORD_W-1:0] w);
    return (WORD_SWAP != 0) ? bswap16(w) : w;
  endfunction

  assign accept = (state == IDLE) && req && !busy;

`ifdef DDRAM_CLIENT_CACHE_EN
  logic [LINE_W-1:0] cache_line;

  ddram_line_cache #(
    .ADDR_W(ADDR_W)
  ) u_cache (
    .DDRAM_CLK (DDRAM_CLK),
    .reset     (reset),
    .lookup_tag(addr[ADDR_W-1:3]),
    .hit       (cache_hit),
    .line      (cache_line),
    .fill_en   ((state == RD_WAIT) && (rd_ack == rd_req)),
    .fill_tag  (rdaddr[ADDR_W-1:3]),
    .fill_line (rd_dout),
    .wr_en     (accept && we),
    .wr_tag    (addr[ADDR_W-1:3]),
    .wr_sel    (addr[2:1]),
    .wr_data   (order(wdata))
  );

  assign hit_word = word_sel(cache_line, addr[2:1]);
`else
  assign cache_hit = 1'b0;
  assign hit_word  = '0;
`endif

  // Transaction FSM: one request in flight, toggles flipped once per request, ack registered.
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      ack    <= 1'b0;
      rdata  <= '0;
      we_req <= 1'b0;
      rd_req <= 1'b0;
      wraddr <= '0;
      rdaddr <= '0;
      wr_din <= '0;
      sel_q  <= '0;
      word_q <= '0;
      is_rd  <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (ack) begin
        busy <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            sel_q <= addr[2:1];
            if (we) begin
              wraddr <= addr;
              wr_din <= order(wdata);
              we_req <= ~we_req;
              is_rd  <= 1'b0;
              state  <= WR_WAIT;
            end else if (cache_hit) begin
              word_q <= hit_word;
              is_rd  <= 1'b1;
              state  <= DONE;
            end else begin
              rdaddr <= {addr[ADDR_W-1:3], 3'b000};
              rd_req <= ~rd_req;
              is_rd  <= 1'b1;
              state  <= RD_WAIT;
            end
          end
        end
        WR_WAIT: begin
          if (we_ack == we_req) begin
            state <= DONE;
          end
        end
        RD_WAIT: begin
          if (rd_ack == rd_req) begin
            word_q <= word_sel(rd_dout, sel_q);
            state  <= DONE;
          end
        end
        default: begin
          ack   <= 1'b1;
          state <= IDLE;
          if (is_rd) begin
            rdata <= order(word_q);
          end
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A request while busy is dropped by the FSM; flag it so the offending core is found.
  req_while_busy : assert property (@(posedge DDRAM_CLK) disable iff (reset) !(req && busy))
    else $warning("ddram_client: req while busy ignored");
`endif

endmodule

// File: tb/tb_ddram_client.sv
// Self-checking bench for ddram_client: a plain-order instance and a byte-swapped
// instance, each with a toggle-handshake DDR model and a word-level reference memory.
module tb_ddram_client;

  localparam int AW    = 28;
  localparam int LIMIT = 200;
`ifdef DDRAM_CLIENT_CACHE_EN
  localparam bit CACHED = 1'b1;
`else
  localparam bit CACHED = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [15:0]   wdata0, wdata1;
  logic [15:0]   rdata0, rdata1, wrDin0, wrDin1;
  logic          ack0, ack1, busy0, busy1;
  logic [AW-1:0] wrAddr0, wrAddr1, rdAddr0, rdAddr1;
  logic          weReq0, weReq1, weAck0, weAck1;
  logic          rdReq0, rdReq1, rdAck0, rdAck1;
  logic [63:0]   rdDout0, rdDout1;

  ddram_client #(.ADDR_W(AW), .WORD_SWAP(0)) dut0 (
    .DDRAM_CLK(clock), .reset(reset), .addr(addr0), .req(req0), .we(we0),
    .wdata(wdata0), .rdata(rdata0), .ack(ack0), .busy(busy0), .wraddr(wrAddr0),
    .wr_din(wrDin0), .we_req(weReq0), .we_ack(weAck0), .rdaddr(rdAddr0),
    .rd_dout(rdDout0), .rd_req(rdReq0), .rd_ack(rdAck0)
  );

  ddram_client #(.ADDR_W(AW), .WORD_SWAP(1)) dut1 (
    .DDRAM_CLK(clock), .reset(reset), .addr(addr1), .req(req1), .we(we1),
    .wdata(wdata1), .rdata(rdata1), .ack(ack1), .busy(busy1), .wraddr(wrAddr1),
    .wr_din(wrDin1), .we_req(weReq1), .we_ack(weAck1), .rdaddr(rdAddr1),
    .rd_dout(rdDout1), .rd_req(rdReq1), .rd_ack(rdAck1)
  );

  // DDR memory contents: preloaded pattern plus an overlay of words written downstream
  bit          ovValid0 [0:4095];
  bit          ovValid1 [0:4095];
  logic [15:0] ovData0  [0:4095];
  logic [15:0] ovData1  [0:4095];
  logic [1:0]  rdDly0, rdDly1, wrDly0, wrDly1;

  // Reference memory in the core's view, plus the expected one-line cache occupancy
  bit          refValid [0:1][0:4095];
  logic [15:0] refVal   [0:1][0:4095];
  bit          cValid   [0:1];
  logic [AW-4:0] cTag   [0:1];

  int rdTog0 = 0, rdTog1 = 0, weTog0 = 0, weTog1 = 0, ackCnt0 = 0, ackCnt1 = 0;
  logic rdPrev0, rdPrev1, wePrev0, wePrev1;

  function automatic logic [15:0] swap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  function automatic logic [15:0] dsInit(input logic [11:0] idx);
    logic [15:0] v;
    if (idx >= 12'h080 && idx <= 12'h083) v = 16'h1111 * (16'(idx) - 16'h007F);
    else if (idx == 12'h104)             v = 16'hABCD;
    else                                 v = (16'(idx) * 16'h9E37) ^ 16'h5A5A;
    return v;
  endfunction

  function automatic logic [15:0] dsWord(input bit inst, input logic [11:0] idx);
    if (!inst) return ovValid0[idx] ? ovData0[idx] : dsInit(idx);
    return ovValid1[idx] ? ovData1[idx] : dsInit(idx);
  endfunction

  function automatic logic [63:0] dsLine(input bit inst, input logic [AW-1:0] a);
    logic [11:0] b;
    b = {a[12:3], 2'b00};
    return {dsWord(inst, b | 12'd3), dsWord(inst, b | 12'd2),
            dsWord(inst, b | 12'd1), dsWord(inst, b)};
  endfunction

  function automatic logic [15:0] refRead(input bit inst, input logic [AW-1:0] a);
    logic [11:0] idx;
    idx = a[12:1];
    if (refValid[inst][idx]) return refVal[inst][idx];
    return inst ? swap16(dsInit(idx)) : dsInit(idx);
  endfunction

  // Downstream stage for the plain instance: answers each toggle three cycles later
  always @(posedge clock) begin
    if (reset) begin
      rdAck0 <= 1'b0; weAck0 <= 1'b0; rdDly0 <= 2'd0; wrDly0 <= 2'd0; rdDout0 <= '0;
    end else begin
      if (rdReq0 != rdAck0) begin
        if (rdDly0 == 2'd2) begin
          rdDout0 <= dsLine(1'b0, rdAddr0); rdAck0 <= rdReq0; rdDly0 <= 2'd0;
        end else rdDly0 <= rdDly0 + 2'd1;
      end
      if (weReq0 != weAck0) begin
        if (wrDly0 == 2'd2) begin
          ovValid0[wrAddr0[12:1]] <= 1'b1; ovData0[wrAddr0[12:1]] <= wrDin0;
          weAck0 <= weReq0; wrDly0 <= 2'd0;
        end else wrDly0 <= wrDly0 + 2'd1;
      end
    end
  end

  // Downstream stage for the byte-swapped instance
  always @(posedge clock) begin
    if (reset) begin
      rdAck1 <= 1'b0; weAck1 <= 1'b0; rdDly1 <= 2'd0; wrDly1 <= 2'd0; rdDout1 <= '0;
    end else begin
      if (rdReq1 != rdAck1) begin
        if (rdDly1 == 2'd2) begin
          rdDout1 <= dsLine(1'b1, rdAddr1); rdAck1 <= rdReq1; rdDly1 <= 2'd0;
        end else rdDly1 <= rdDly1 + 2'd1;
      end
      if (weReq1 != weAck1) begin
        if (wrDly1 == 2'd2) begin
          ovValid1[wrAddr1[12:1]] <= 1'b1; ovData1[wrAddr1[12:1]] <= wrDin1;
          weAck1 <= weReq1; wrDly1 <= 2'd0;
        end else wrDly1 <= wrDly1 + 2'd1;
      end
    end
  end

  // Count new requests (toggle that opens a pending request) and ack pulses
  always @(posedge clock) begin
    rdPrev0 <= rdReq0; rdPrev1 <= rdReq1; wePrev0 <= weReq0; wePrev1 <= weReq1;
    if (rdReq0 !== rdPrev0 && rdReq0 !== rdAck0) rdTog0 <= rdTog0 + 1;
    if (rdReq1 !== rdPrev1 && rdReq1 !== rdAck1) rdTog1 <= rdTog1 + 1;
    if (weReq0 !== wePrev0 && weReq0 !== weAck0) weTog0 <= weTog0 + 1;
    if (weReq1 !== wePrev1 && weReq1 !== weAck1) weTog1 <= weTog1 + 1;
    if (ack0 === 1'b1) ackCnt0 <= ackCnt0 + 1;
    if (ack1 === 1'b1) ackCnt1 <= ackCnt1 + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One request pulse, then wait (bounded) for ack; returns at the negedge of the ack cycle
  task automatic applyStimulus(input bit inst, input bit isWr, input logic [AW-1:0] a,
                               input logic [15:0] d, input string tag, output int lat);
    @(posedge clock); #1;
    if (!inst) begin req0 = 1'b1; we0 = isWr; addr0 = a; wdata0 = d; end
    else       begin req1 = 1'b1; we1 = isWr; addr1 = a; wdata1 = d; end
    @(posedge clock); #1;
    req0 = 1'b0; req1 = 1'b0;
    lat = 1;
    while (lat < LIMIT) begin
      @(negedge clock);
      if ((inst ? ack1 : ack0) === 1'b1) break;
      @(posedge clock); #1;
      lat++;
    end
    checkOutput({tag, "_ack_seen"}, 64'(lat < LIMIT), 64'd1);
  endtask

  task automatic doRead(input bit inst, input logic [AW-1:0] a, input string tag);
    int lat, togBefore, ackBefore;
    bit expHit;
    logic [15:0] expData;
    expData   = refRead(inst, a);
    expHit    = CACHED && cValid[inst] && (cTag[inst] == a[AW-1:3]);
    togBefore = inst ? rdTog1 : rdTog0;
    ackBefore = inst ? ackCnt1 : ackCnt0;
    applyStimulus(inst, 1'b0, a, 16'h0000, tag, lat);
    checkOutput({tag, "_rdata"}, 64'(inst ? rdata1 : rdata0), 64'(expData));
    if (expHit) checkOutput({tag, "_hit_latency"}, 64'(lat), 64'd2);
    @(posedge clock); #1;
    checkOutput({tag, "_rd_toggles"}, 64'((inst ? rdTog1 : rdTog0) - togBefore),
                expHit ? 64'd0 : 64'd1);
    checkOutput({tag, "_acks"}, 64'((inst ? ackCnt1 : ackCnt0) - ackBefore), 64'd1);
    cValid[inst] = 1'b1;
    cTag[inst]   = a[AW-1:3];
  endtask

  task automatic doWrite(input bit inst, input logic [AW-1:0] a, input logic [15:0] d,
                         input string tag);
    int lat, togBefore;
    togBefore = inst ? weTog1 : weTog0;
    applyStimulus(inst, 1'b1, a, d, tag, lat);
    checkOutput({tag, "_wraddr"}, 64'(inst ? wrAddr1 : wrAddr0), 64'(a));
    checkOutput({tag, "_wr_din"}, 64'(inst ? wrDin1 : wrDin0), 64'(inst ? swap16(d) : d));
    @(posedge clock); #1;
    checkOutput({tag, "_we_toggles"}, 64'((inst ? weTog1 : weTog0) - togBefore), 64'd1);
    refValid[inst][a[12:1]] = 1'b1;
    refVal[inst][a[12:1]]   = d;
  endtask

  initial begin
    int ackBefore, weBefore, togBefore, n;
    logic [AW-1:0] ra;
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    cValid[0] = 1'b0; cValid[1] = 1'b0; cTag[0] = '0; cTag[1] = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    $display("[TB] reset values");
    checkOutput("rst_rdata", 64'(rdata0), 64'd0);
    checkOutput("rst_ack", 64'(ack0), 64'd0);
    checkOutput("rst_busy", 64'(busy0), 64'd0);
    checkOutput("rst_we_req", 64'(weReq0), 64'd0);
    checkOutput("rst_rd_req", 64'(rdReq0), 64'd0);
    checkOutput("rst_wraddr", 64'(wrAddr0), 64'd0);
    checkOutput("rst_rdaddr", 64'(rdAddr0), 64'd0);
    checkOutput("rst_wr_din", 64'(wrDin0), 64'd0);

    $display("[TB] line read, same-line read, write then read back");
    doRead(1'b0, 28'h100, "s1");
    checkOutput("s1_rdata_const", 64'(rdata0), 64'h1111);
    checkOutput("s1_rdaddr", 64'(rdAddr0), 64'h100);
    doRead(1'b0, 28'h106, "s2");
    checkOutput("s2_rdata_const", 64'(rdata0), 64'h4444);
    doWrite(1'b0, 28'h102, 16'hBEEF, "s3w");
    doRead(1'b0, 28'h102, "s3r");
    checkOutput("s3_rdata_const", 64'(rdata0), 64'hBEEF);

    $display("[TB] byte-swapped instance");
    doWrite(1'b1, 28'h240, 16'h1234, "s4w");
    checkOutput("s4_wr_din_const", 64'(wrDin1), 64'h3412);
    doRead(1'b1, 28'h208, "s4r");
    checkOutput("s4_rdata_const", 64'(rdata1), 64'hCDAB);
    doRead(1'b1, 28'h240, "s4rb");

    $display("[TB] reset while waiting for a read line");
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 28'h300;
    @(posedge clock); #1;
    req0 = 1'b0;
    @(negedge clock);
    checkOutput("s5_pending", 64'(rdReq0 ^ rdAck0), 64'd1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("s5_busy", 64'(busy0), 64'd0);
    checkOutput("s5_rd_req", 64'(rdReq0), 64'd0);
    cValid[0] = 1'b0; cValid[1] = 1'b0;
    doRead(1'b0, 28'h100, "s5_fresh");

    $display("[TB] request while busy");
    ackBefore = ackCnt0; weBefore = weTog0; togBefore = rdTog0;
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 28'h400;
    @(posedge clock); #1;
    req0 = 1'b0;
    @(posedge clock); #1;
    checkOutput("s6_busy_at_stray", 64'(busy0), 64'd1);
    req0 = 1'b1; we0 = 1'b1; addr0 = 28'h500; wdata0 = 16'h5555;
    @(posedge clock); #1;
    req0 = 1'b0; we0 = 1'b0;
    n = 0;
    while (n < LIMIT) begin
      @(negedge clock);
      if (ack0 === 1'b1) break;
      @(posedge clock); #1;
      n++;
    end
    checkOutput("s6_ack_seen", 64'(n < LIMIT), 64'd1);
    checkOutput("s6_rdata", 64'(rdata0), 64'(refRead(1'b0, 28'h400)));
    repeat (4) @(posedge clock);
    #1;
    checkOutput("s6_acks", 64'(ackCnt0 - ackBefore), 64'd1);
    checkOutput("s6_we_toggles", 64'(weTog0 - weBefore), 64'd0);
    checkOutput("s6_rd_toggles", 64'(rdTog0 - togBefore), 64'd1);
    checkOutput("s6_idle", 64'(busy0), 64'd0);
    cValid[0] = 1'b1; cTag[0] = 25'(28'h400 >> 3);

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      bit inst;
      inst = 1'($urandom_range(0, 1));
      ra = 28'h100 + 28'(2 * $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) doWrite(inst, ra, 16'($urandom), "rnd_w");
      else                           doRead(inst, ra, "rnd_r");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
